// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester IDs and widths.
package mem_arb_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker; grant[0] = IFU, grant[1] = LSU.
// MEM_ARB_RR_EN selects round-robin on ties, otherwise LSU has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_valid,
  input  logic       ls_valid,
`ifdef MEM_ARB_RR_EN
  input  req_t       last,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first
    if (if_valid && ls_valid) begin
      grant = (last == REQ_IF) ? 2'b10 : 2'b01;
    end else begin
      grant = {ls_valid, if_valid};
    end
`else
    if (ls_valid) begin
      grant = 2'b10;
    end else if (if_valid) begin
      grant = 2'b01;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one transaction at a time.
// Optional MEM_ARB_RR_EN: round-robin grant instead of fixed LSU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_read_en,
  output logic                mem_write_en,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   cnt;
  req_t                owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [1:0]          grant;
  logic                accept;
  logic                last_cycle;

  assign last_cycle = (cnt == '0);

`ifdef MEM_ARB_RR_EN
  req_t rr_last;

  mem_arb_pick u_pick (
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .last     (rr_last),
    .grant    (grant)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last <= REQ_IF;
    end else if (accept) begin
      rr_last <= grant[1] ? REQ_LS : REQ_IF;
    end
  end
`else
  mem_arb_pick u_pick (
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant    (grant)
  );
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and memory-port decode; the write strobe is masked while reset is low
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    mem_raddr    = '0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        if_req_ready = 1'b1;
        ls_req_ready = 1'b1;
        accept       = |grant;
        if (accept) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_raddr   = addr_q;
        mem_waddr   = addr_q;
        mem_read_en = !wen_q;
        if (wen_q) begin
          mem_wdata = wdata_q;
          mem_wmask = wmask_q;
        end
        mem_write_en = wen_q && last_cycle && reset;
        if (last_cycle) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and registered responses
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt           <= '0;
      owner         <= REQ_IF;
      addr_q        <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      ls_resp_valid <= 1'b0;
      ls_resp_data  <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if (accept) begin
        owner   <= grant[1] ? REQ_LS : REQ_IF;
        addr_q  <= grant[1] ? ls_req_addr : if_req_addr;
        wen_q   <= grant[1] & ls_req_wen;
        wdata_q <= ls_req_wdata;
        wmask_q <= ls_req_wmask;
        cnt     <= WAIT_W'(WAIT_CYCLES);
      end else if (state == ACCESS && !last_cycle) begin
        cnt <= cnt - WAIT_W'(1);
      end
      if (state == ACCESS && last_cycle) begin
        if (owner == REQ_IF) begin
          if_resp_valid <= 1'b1;
          if_resp_data  <= mem_rdata;
        end else begin
          ls_resp_valid <= 1'b1;
          ls_resp_data  <= wen_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// Build with +define+MEM_ARB_RR_EN to check the round-robin grant.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clock;
  logic        reset;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [63:0] if_resp_data;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [63:0] ls_req_addr;
  logic        ls_req_wen;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_data;
  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [63:0] mem_rdata;

  mem_arbiter #(
    .ADDR_W      (64),
    .DATA_W      (64),
    .WAIT_CYCLES (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wen    (ls_req_wen),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wmask  (ls_req_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_data  (ls_resp_data),
    .mem_raddr     (mem_raddr),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_rdata     (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory seen by the DUT (env) and the model's expected memory image (ref)
  logic [63:0] env_mem [8];
  logic [63:0] ref_mem [8];
  assign mem_rdata = env_mem[mem_raddr[5:3]];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          phase    = -1;
  bit          cur_ls;
  bit          cur_wen;
  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [7:0]  cur_wmask;
  bit          rr_last_ls = 1'b0;
  bit          if_taken;
  bit          ls_taken;
  bit          resp_order [$];
  bit          exp_order  [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_addr();
    return 64'h8000_0000 + 64'(8 * $urandom_range(0, 7));
  endfunction

  // Transaction-level view of one rising edge: memory write, reset, progress, acceptance
  task automatic model_edge();
    bit pick_ls;
    if_taken = 1'b0;
    ls_taken = 1'b0;
    if (mem_write_en) begin
      env_mem[mem_waddr[5:3]] = merge(env_mem[mem_waddr[5:3]], mem_wdata, mem_wmask);
    end
    if (!reset) begin
      phase      = -1;
      rr_last_ls = 1'b0;
      return;
    end
    if (phase == 1 + W && cur_wen) begin
      ref_mem[cur_addr[5:3]] = merge(ref_mem[cur_addr[5:3]], cur_wdata, cur_wmask);
    end
    if (phase >= 1) begin
      phase++;
      if (phase == 3 + W) phase = -1;
    end else if (if_req_valid || ls_req_valid) begin
`ifdef MEM_ARB_RR_EN
      if (if_req_valid && ls_req_valid) pick_ls = !rr_last_ls;
      else                              pick_ls = ls_req_valid;
      rr_last_ls = pick_ls;
`else
      pick_ls = ls_req_valid;
`endif
      phase     = 1;
      cur_ls    = pick_ls;
      cur_addr  = pick_ls ? ls_req_addr : if_req_addr;
      cur_wen   = pick_ls && ls_req_wen;
      cur_wdata = ls_req_wdata;
      cur_wmask = ls_req_wmask;
      if_taken  = !pick_ls;
      ls_taken  = pick_ls;
    end
  endtask

  task automatic check_cycle();
    bit idle, acc, wr, ifv, lsv;
    idle = (phase < 0);
    acc  = (phase >= 1) && (phase <= 1 + W);
    wr   = acc && cur_wen && (phase == 1 + W) && (reset == 1'b1);
    ifv  = (phase == 2 + W) && !cur_ls;
    lsv  = (phase == 2 + W) && cur_ls;
    check_eq("if_req_ready", 64'(if_req_ready), 64'(idle));
    check_eq("ls_req_ready", 64'(ls_req_ready), 64'(idle));
    check_eq("mem_read_en", 64'(mem_read_en), 64'(acc && !cur_wen));
    check_eq("mem_write_en", 64'(mem_write_en), 64'(wr));
    check_eq("mem_raddr", mem_raddr, acc ? cur_addr : 64'h0);
    check_eq("mem_waddr", mem_waddr, acc ? cur_addr : 64'h0);
    if (wr) begin
      check_eq("mem_wdata", mem_wdata, cur_wdata);
      check_eq("mem_wmask", 64'(mem_wmask), 64'(cur_wmask));
    end else if (!acc) begin
      check_eq("mem_wdata_idle", mem_wdata, 64'h0);
      check_eq("mem_wmask_idle", 64'(mem_wmask), 64'h0);
    end
    check_eq("if_resp_valid", 64'(if_resp_valid), 64'(ifv));
    check_eq("ls_resp_valid", 64'(ls_resp_valid), 64'(lsv));
    if (ifv) check_eq("if_resp_data", if_resp_data, ref_mem[cur_addr[5:3]]);
    if (lsv) check_eq("ls_resp_data", ls_resp_data, cur_wen ? 64'h0 : ref_mem[cur_addr[5:3]]);
    if (ls_resp_valid) resp_order.push_back(1'b1);
    if (if_resp_valid) resp_order.push_back(1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    check_cycle();
  endtask

  task automatic drive_random();
    if (!if_req_valid || if_taken) begin
      if_req_valid = ($urandom_range(0, 2) != 0);
      if_req_addr  = rand_addr();
    end
    if (!ls_req_valid || ls_taken) begin
      ls_req_valid = ($urandom_range(0, 2) != 0);
      ls_req_addr  = rand_addr();
      ls_req_wen   = 1'($urandom_range(0, 1));
      ls_req_wdata = {$urandom, $urandom};
      ls_req_wmask = 8'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      env_mem[i] = {32'h1000_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)};
      ref_mem[i] = env_mem[i];
    end
    env_mem[0] = 64'h0000_0013;
    ref_mem[0] = 64'h0000_0013;
    reset        = 1'b0;
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    ls_req_valid = 1'b0;
    ls_req_addr  = '0;
    ls_req_wen   = 1'b0;
    ls_req_wdata = '0;
    ls_req_wmask = '0;
    @(negedge clock);
    tick();
    tick();
    check_eq("reset_if_resp_data", if_resp_data, 64'h0);
    check_eq("reset_ls_resp_data", ls_resp_data, 64'h0);
    reset = 1'b1;
    tick();

    // Single IFU fetch returning 0x13
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0000;
    tick();
    if_req_valid = 1'b0;
    for (int i = 0; i < W + 3; i++) tick();

    // Held tie on both requesters for four transactions
    resp_order.delete();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0010;
    ls_req_valid = 1'b1;
    ls_req_addr  = 64'h8000_0018;
    ls_req_wen   = 1'b0;
    for (int i = 0; i < 60 && resp_order.size() < 4; i++) tick();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    check_eq("tie_resp_count", 64'(resp_order.size()), 64'd4);
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < resp_order.size()) check_eq("tie_grant_order", 64'(resp_order[i]), 64'(exp_order[i]));
    end
    for (int i = 0; i < 3; i++) tick();

    // Reset in the first ACCESS cycle of a store drops it entirely
    ls_req_valid = 1'b1;
    ls_req_addr  = 64'h8000_0008;
    ls_req_wen   = 1'b1;
    ls_req_wdata = 64'h0000_0000_DEAD_BEEF;
    ls_req_wmask = 8'h0F;
    tick();
    ls_req_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < W + 3; i++) tick();
    check_eq("dropped_store_mem", env_mem[1], ref_mem[1]);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    for (int i = 0; i < W + 4; i++) tick();
    for (int i = 0; i < 8; i++) check_eq("final_mem", env_mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
